// File: rtl/pulse_recover.sv
// Measures level pulses on a single-bit line and recovers one-cycle event strobes.
// Flags pulses shorter than MIN_WIDTH as glitches and longer than MAX_WIDTH as overflow.
module pulse_recover #(
  parameter int MIN_WIDTH = 2,
  parameter int MAX_WIDTH = 255,
  parameter int CNTR_W    = $clog2(MAX_WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              start,
  output logic              done,
  output logic [CNTR_W-1:0] width_out,
  output logic              glitch,
  output logic              ovf
);

  if (MIN_WIDTH < 1 || MIN_WIDTH > MAX_WIDTH) begin : g_param_err
    $error("pulse_recover: MIN_WIDTH must satisfy 1 <= MIN_WIDTH <= MAX_WIDTH");
  end

  localparam logic [CNTR_W-1:0] ONE_C = CNTR_W'(1);
  localparam logic [CNTR_W-1:0] MIN_C = CNTR_W'(MIN_WIDTH);
  localparam logic [CNTR_W-1:0] MAX_C = CNTR_W'(MAX_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_OVF
  } state_t;

  state_t            state_q, state_d;
  logic [CNTR_W-1:0] cntr_q, cntr_d;
  logic [CNTR_W-1:0] width_q, width_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              glitch_q, glitch_d;
  logic              ovf_q, ovf_d;

  // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cntr_d   = cntr_q;
    width_d  = width_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    glitch_d = 1'b0;
    ovf_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d = ST_MEASURE;
          cntr_d  = ONE_C;
          if (MIN_WIDTH == 1) start_d = 1'b1;
        end
      end

      ST_MEASURE: begin
        if (in) begin
          if (cntr_q == MAX_C) begin
            // Counter saturates; this pulse will never report done.
            state_d = ST_OVF;
            ovf_d   = 1'b1;
          end else begin
            cntr_d = cntr_q + ONE_C;
            if (cntr_q + ONE_C == MIN_C) start_d = 1'b1;
          end
        end else begin
          if (cntr_q >= MIN_C) begin
            done_d  = 1'b1;
            width_d = cntr_q;
          end else begin
            glitch_d = 1'b1;
          end
          state_d = ST_IDLE;
          cntr_d  = '0;
        end
      end

      ST_OVF: begin
        if (!in) begin
          state_d = ST_IDLE;
          cntr_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cntr_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cntr_q   <= '0;
      width_q  <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      glitch_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cntr_q   <= cntr_d;
      width_q  <= width_d;
      start_q  <= start_d;
      done_q   <= done_d;
      glitch_q <= glitch_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start     = start_q;
  assign done      = done_q;
  assign width_out = width_q;
  assign glitch    = glitch_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_recover.sv
// Directed bench for pulse_recover: MIN_WIDTH=2/MAX_WIDTH=8 instance plus a MIN_WIDTH=1 instance.
module tb_pulse_recover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_a = 1'b0;
  logic       in_b = 1'b0;

  logic       start_a, done_a, glitch_a, ovf_a;
  logic [3:0] width_a;
  logic       start_b, done_b, glitch_b, ovf_b;
  logic [3:0] width_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Per-run tallies filled in by run_pulse.
  int idx, start_cnt, done_cnt, glitch_cnt, ovf_cnt, multi_cnt;
  int start_at, done_at, glitch_at, ovf_at;
  int w_first, w_last;

  always #5 clk = ~clk;

  pulse_recover #(.MIN_WIDTH(2), .MAX_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .start(start_a), .done(done_a), .width_out(width_a), .glitch(glitch_a), .ovf(ovf_a)
  );

  pulse_recover #(.MIN_WIDTH(1), .MAX_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .in(in_b),
    .start(start_b), .done(done_b), .width_out(width_b), .glitch(glitch_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    idx = 0; start_cnt = 0; done_cnt = 0; glitch_cnt = 0; ovf_cnt = 0; multi_cnt = 0;
    start_at = 0; done_at = 0; glitch_at = 0; ovf_at = 0; w_first = -1; w_last = -1;
  endtask

  // One clock: drive the selected line, let the edge happen, then observe 1 ns later.
  task automatic step(input bit sel, input logic v);
    logic s, d, g, o;
    int   w;
    if (sel) in_b = v; else in_a = v;
    @(posedge clk);
    #1;
    idx++;
    s = sel ? start_b  : start_a;
    d = sel ? done_b   : done_a;
    g = sel ? glitch_b : glitch_a;
    o = sel ? ovf_b    : ovf_a;
    w = sel ? int'(width_b) : int'(width_a);
    if (s) begin start_cnt++; if (start_at == 0) start_at = idx; end
    if (d) begin
      done_cnt++;
      if (done_at == 0) done_at = idx;
      if (w_first < 0) w_first = w;
      w_last = w;
    end
    if (g) begin glitch_cnt++; if (glitch_at == 0) glitch_at = idx; end
    if (o) begin ovf_cnt++; if (ovf_at == 0) ovf_at = idx; end
    if (int'(d) + int'(g) + int'(o) > 1) multi_cnt++;
  endtask

  task automatic run_pulse(input bit sel, input int n_high, input int n_low);
    for (int i = 0; i < n_high; i++) step(sel, 1'b1);
    for (int i = 0; i < n_low; i++) step(sel, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_start",  int'(start_a),  0);
    check("rst_done",   int'(done_a),   0);
    check("rst_width",  int'(width_a),  0);
    check("rst_glitch", int'(glitch_a), 0);
    check("rst_ovf",    int'(ovf_a),    0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 5-cycle pulse
    clear_tally();
    run_pulse(0, 5, 2);
    check("p5_start_cnt", start_cnt, 1);
    check("p5_start_at",  start_at,  2);
    check("p5_done_cnt",  done_cnt,  1);
    check("p5_done_at",   done_at,   6);
    check("p5_width",     w_first,   5);
    check("p5_glitch",    glitch_cnt, 0);
    check("p5_ovf",       ovf_cnt,   0);

    // 1-cycle glitch
    clear_tally();
    run_pulse(0, 1, 2);
    check("g1_glitch_cnt", glitch_cnt, 1);
    check("g1_glitch_at",  glitch_at,  2);
    check("g1_start_cnt",  start_cnt,  0);
    check("g1_done_cnt",   done_cnt,   0);
    check("g1_width_held", int'(width_a), 5);

    // Exactly MAX_WIDTH
    clear_tally();
    run_pulse(0, 8, 2);
    check("p8_done_cnt", done_cnt, 1);
    check("p8_done_at",  done_at,  9);
    check("p8_width",    w_first,  8);
    check("p8_ovf",      ovf_cnt,  0);

    // MAX_WIDTH+1 overflows
    clear_tally();
    run_pulse(0, 9, 2);
    check("p9_start_cnt", start_cnt, 1);
    check("p9_ovf_cnt",   ovf_cnt,   1);
    check("p9_ovf_at",    ovf_at,    9);
    check("p9_done_cnt",  done_cnt,  0);
    check("p9_width_held", int'(width_a), 8);

    // Back in IDLE: a 2-cycle pulse measures cleanly
    clear_tally();
    run_pulse(0, 2, 2);
    check("p2_done_cnt",  done_cnt,  1);
    check("p2_width",     w_first,   2);
    check("p2_start_at",  start_at,  2);

    // Back-to-back 3 / 4 with a single low sample
    clear_tally();
    run_pulse(0, 3, 1);
    run_pulse(0, 4, 2);
    check("bb_done_cnt",  done_cnt,  2);
    check("bb_start_cnt", start_cnt, 2);
    check("bb_width_1",   w_first,   3);
    check("bb_width_2",   w_last,    4);
    check("bb_done_at",   done_at,   4);

    // Async reset mid-pulse
    clear_tally();
    run_pulse(0, 3, 0);
    #3 rst = 1'b1;
    #1;
    check("ar_start",  int'(start_a),  0);
    check("ar_done",   int'(done_a),   0);
    check("ar_width",  int'(width_a),  0);
    check("ar_glitch", int'(glitch_a), 0);
    check("ar_ovf",    int'(ovf_a),    0);
    #1 rst = 1'b0;
    clear_tally();
    run_pulse(0, 4, 2);
    check("ar_start_at", start_at, 2);
    check("ar_done_cnt", done_cnt, 1);
    check("ar_done_at",  done_at,  5);
    check("ar_width_4",  w_first,  4);
    check("ar_glitch_cnt", glitch_cnt, 0);

    // MIN_WIDTH=1 instance, single-cycle pulse
    clear_tally();
    run_pulse(1, 1, 2);
    check("m1_start_cnt", start_cnt, 1);
    check("m1_start_at",  start_at,  1);
    check("m1_done_at",   done_at,   2);
    check("m1_width",     w_first,   1);
    check("m1_glitch",    glitch_cnt, 0);
    check("m1_exclusive", multi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
